// File: rtl/retire_trace_packer.sv
// Retirement trace packer: buffers one record per retired instruction and
// streams each record as a 9-byte packet (header, PC, instruction) over valid/ready.
module retire_trace_packer #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ret_valid,
  input  logic [31:0]              ret_pc,
  input  logic [31:0]              ret_instr,
  input  logic [4:0]               ret_rdn,
  input  logic                     ret_regwrite,
  input  logic                     ret_exit,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_count,
  output logic                     done
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int REC_W = 72;

  typedef enum logic {IDLE, SEND} serStateT;

  logic [REC_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;

  logic             retExitQ;
  logic             exitSeen;
  logic             pendingExit;
  logic [69:0]      pendRec;
  logic             dropMark;

  logic [REC_W-1:0] shiftRec;
  logic [3:0]       idx;
  logic [3:0]       idxNext;
  serStateT         state;
  serStateT         nextState;
  logic             pop;
  logic             lastExitAccept;

  logic             fifoFull;
  logic             fifoEmpty;
  logic             room;
  logic             exitEdge;
  logic             capture;
  logic             liveRw;
  logic             pendWrite;
  logic             doWrite;
  logic             dropRec;
  logic             holdExit;
  logic [REC_W-1:0] wrData;

  assign fifoFull  = (fifo_count == CW'(DEPTH));
  assign fifoEmpty = (fifo_count == '0);
  assign room      = !fifoFull || pop;
  assign exitEdge  = ret_exit && !retExitQ && !exitSeen;
  assign capture   = !exitSeen && (ret_valid || exitEdge);
  assign liveRw    = ret_regwrite && ret_valid;
  assign pendWrite = pendingExit && room;
  assign doWrite   = pendWrite || (capture && room);
  assign dropRec   = capture && !room && !exitEdge;
  assign holdExit  = capture && !room && exitEdge;

  // Record layout {H, pc, instr}; the drop mark is folded into H at write time
  always_comb begin
    wrData = {exitEdge, liveRw, dropMark, ret_rdn, ret_pc, ret_instr};
    if (pendWrite) begin
      wrData = {1'b1, pendRec[69], dropMark, pendRec[68:64], pendRec[63:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (doWrite) begin
      mem[wrPtr] <= wrData;
    end
  end

  // Capture side: the core cannot stall, so a full FIFO drops ordinary records
  // while an exit record waits in a one-entry holding slot
  always_ff @(posedge clk) begin
    if (rst) begin
      retExitQ    <= 1'b0;
      exitSeen    <= 1'b0;
      pendingExit <= 1'b0;
      pendRec     <= '0;
      dropMark    <= 1'b0;
      overflow    <= 1'b0;
      drop_count  <= '0;
      wrPtr       <= '0;
      rdPtr       <= '0;
      fifo_count  <= '0;
    end else begin
      retExitQ <= ret_exit;
      if (exitEdge) begin
        exitSeen <= 1'b1;
      end
      if (holdExit) begin
        pendingExit <= 1'b1;
        pendRec     <= {liveRw, ret_rdn, ret_pc, ret_instr};
      end else if (pendWrite) begin
        pendingExit <= 1'b0;
      end
      if (doWrite) begin
        wrPtr    <= wrPtr + AW'(1);
        dropMark <= 1'b0;
      end
      if (dropRec) begin
        overflow <= 1'b1;
        dropMark <= 1'b1;
        if (drop_count != '1) begin
          drop_count <= drop_count + CNT_W'(1);
        end
      end
      if (pop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      fifo_count <= fifo_count + CW'(doWrite) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      shiftRec <= '0;
      done     <= 1'b0;
    end else begin
      state <= nextState;
      idx   <= idxNext;
      if (pop) begin
        shiftRec <= mem[rdPtr];
      end
      if (lastExitAccept) begin
        done <= 1'b1;
      end
    end
  end

  // Serializer: back-to-back packets without a bubble; once the exit packet
  // has gone out the FSM parks in IDLE for good
  always_comb begin
    nextState      = state;
    idxNext        = idx;
    pop            = 1'b0;
    lastExitAccept = 1'b0;
    case (state)
      IDLE: begin
        if (!fifoEmpty && !done) begin
          pop       = 1'b1;
          idxNext   = '0;
          nextState = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (idx == 4'd8) begin
            if (shiftRec[71]) begin
              lastExitAccept = 1'b1;
              nextState      = IDLE;
            end else if (!fifoEmpty) begin
              pop     = 1'b1;
              idxNext = '0;
            end else begin
              nextState = IDLE;
            end
          end else begin
            idxNext = idx + 4'd1;
          end
        end
      end
      default: nextState = IDLE;
    endcase
  end

  assign tx_valid = (state == SEND);

  always_comb begin
    tx_data = shiftRec[71:64];
    case (idx)
      4'd1:    tx_data = shiftRec[39:32];
      4'd2:    tx_data = shiftRec[47:40];
      4'd3:    tx_data = shiftRec[55:48];
      4'd4:    tx_data = shiftRec[63:56];
      4'd5:    tx_data = shiftRec[7:0];
      4'd6:    tx_data = shiftRec[15:8];
      4'd7:    tx_data = shiftRec[23:16];
      4'd8:    tx_data = shiftRec[31:24];
      default: tx_data = shiftRec[71:64];
    endcase
  end

endmodule

// File: tb/tb_retire_trace_packer.sv
// Bench for retire_trace_packer: expected packet bytes are queued as records
// are driven and compared as the sink accepts them.
module tb_retire_trace_packer;

  logic        clock;
  logic        reset;
  logic        retValid;
  logic [31:0] retPc;
  logic [31:0] retInstr;
  logic [4:0]  retRdn;
  logic        retRegwrite;
  logic        retExit;
  logic [7:0]  txData;
  logic        txValid;
  logic        txReady;
  logic [4:0]  fifoCount;
  logic        overflow;
  logic [15:0] dropCount;
  logic        done;

  int checkCount = 0;
  int passCount  = 0;
  int validCycles = 0;
  int acceptedCount = 0;
  logic [7:0] expBytes [$];
  logic       prevStall = 1'b0;
  logic [7:0] prevData  = 8'h00;

  retire_trace_packer #(.DEPTH(16), .CNT_W(16)) dut (
    .clk(clock), .rst(reset),
    .ret_valid(retValid), .ret_pc(retPc), .ret_instr(retInstr),
    .ret_rdn(retRdn), .ret_regwrite(retRegwrite), .ret_exit(retExit),
    .tx_data(txData), .tx_valid(txValid), .tx_ready(txReady),
    .fifo_count(fifoCount), .overflow(overflow),
    .drop_count(dropCount), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end else begin
      passCount++;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pushRecord(input logic [7:0] hdr, input logic [31:0] pc, input logic [31:0] instr);
    expBytes.push_back(hdr);
    for (int b = 0; b < 4; b++) expBytes.push_back(pc[8*b +: 8]);
    for (int b = 0; b < 4; b++) expBytes.push_back(instr[8*b +: 8]);
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                               input logic [4:0] rdn, input logic rw);
    retValid    = v;
    retPc       = pc;
    retInstr    = instr;
    retRdn      = rdn;
    retRegwrite = rw;
    tick(1);
    retValid = 1'b0;
  endtask

  task automatic checkResetState();
    checkOutput("rstTxValid", 32'(txValid), 32'd0);
    checkOutput("rstTxData", 32'(txData), 32'd0);
    checkOutput("rstFifoCount", 32'(fifoCount), 32'd0);
    checkOutput("rstOverflow", 32'(overflow), 32'd0);
    checkOutput("rstDropCount", 32'(dropCount), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
  endtask

  task automatic resetDut();
    reset    = 1'b1;
    retValid = 1'b0;
    retExit  = 1'b0;
    tick(2);
    reset = 1'b0;
    expBytes.delete();
    checkResetState();
  endtask

  task automatic waitDrain(input string tag, input int budget, input logic toggle);
    int n = 0;
    while (!(expBytes.size() == 0 && !txValid) && n < budget) begin
      if (toggle) txReady = !txReady;
      tick(1);
      n++;
    end
    checkOutput(tag, 32'(expBytes.size() == 0 && !txValid), 32'd1);
    txReady = 1'b1;
  endtask

  // Sink-side monitor sampling on the falling edge
  always @(negedge clock) begin
    if (reset) begin
      prevStall = 1'b0;
    end else begin
      if (txValid) validCycles++;
      if (prevStall) begin
        checkOutput("stallValid", 32'(txValid), 32'd1);
        checkOutput("stallData", 32'(txData), 32'(prevData));
      end
      if (txValid && txReady) begin
        acceptedCount++;
        if (expBytes.size() == 0) begin
          checkOutput("extraByte", 32'(txData), 32'h100);
        end else begin
          checkOutput("txByte", 32'(txData), 32'(expBytes.pop_front()));
        end
      end
      prevStall = txValid && !txReady;
      prevData  = txData;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int startValid;
    int startAcc;
    int n;
    reset = 1'b1; retValid = 1'b0; retPc = '0; retInstr = '0; retRdn = '0;
    retRegwrite = 1'b0; retExit = 1'b0; txReady = 1'b1;

    // T1: single record, sink always ready
    resetDut();
    startValid = validCycles;
    pushRecord(8'h41, 32'h0000_0100, 32'h00A0_0093);
    applyStimulus(1'b1, 32'h0000_0100, 32'h00A0_0093, 5'd1, 1'b1);
    checkOutput("t1CountAfterCapture", 32'(fifoCount), 32'd1);
    checkOutput("t1ValidLowAfterCapture", 32'(txValid), 32'd0);
    tick(1);
    checkOutput("t1ValidHigh", 32'(txValid), 32'd1);
    checkOutput("t1FirstByte", 32'(txData), 32'h41);
    checkOutput("t1CountAfterPop", 32'(fifoCount), 32'd0);
    waitDrain("t1Drain", 40, 1'b0);
    checkOutput("t1ValidCycles", 32'(validCycles - startValid), 32'd9);
    checkOutput("t1Done", 32'(done), 32'd0);

    // T2: same record with tx_ready toggling every cycle
    resetDut();
    txReady = 1'b0;
    startValid = validCycles;
    startAcc = acceptedCount;
    pushRecord(8'h41, 32'h0000_0100, 32'h00A0_0093);
    applyStimulus(1'b1, 32'h0000_0100, 32'h00A0_0093, 5'd1, 1'b1);
    waitDrain("t2Drain", 60, 1'b1);
    checkOutput("t2ValidCycles", 32'(validCycles - startValid), 32'd18);
    checkOutput("t2Accepted", 32'(acceptedCount - startAcc), 32'd9);

    // T3: overflow with a stalled sink; the first record parks in the serializer
    resetDut();
    txReady = 1'b0;
    pushRecord(8'h03, 32'hFFFF_0000, 32'h0000_0000);
    applyStimulus(1'b1, 32'hFFFF_0000, 32'h0000_0000, 5'd3, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (i < 16) pushRecord(8'h40 | 8'(i), 32'(4 * i), 32'h1000_0000 + 32'(i));
      applyStimulus(1'b1, 32'(4 * i), 32'h1000_0000 + 32'(i), 5'(i), 1'b1);
    end
    checkOutput("t3FifoFull", 32'(fifoCount), 32'd16);
    checkOutput("t3DropCount", 32'(dropCount), 32'd4);
    checkOutput("t3Overflow", 32'(overflow), 32'd1);
    txReady = 1'b1;
    tick(9);
    txReady = 1'b0;
    checkOutput("t3OneDrained", 32'(fifoCount), 32'd15);
    pushRecord(8'h65, 32'h0000_0100, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 5'd5, 1'b1);
    checkOutput("t3RefilledCount", 32'(fifoCount), 32'd16);
    checkOutput("t3DropsUnchanged", 32'(dropCount), 32'd4);
    txReady = 1'b1;
    waitDrain("t3Drain", 400, 1'b0);

    // T6: reset mid-packet, carrying the drop state from T3
    startAcc = acceptedCount;
    pushRecord(8'h47, 32'h0000_0300, 32'hAABB_CCDD);
    pushRecord(8'h48, 32'h0000_0304, 32'h1122_3344);
    applyStimulus(1'b1, 32'h0000_0300, 32'hAABB_CCDD, 5'd7, 1'b1);
    applyStimulus(1'b1, 32'h0000_0304, 32'h1122_3344, 5'd8, 1'b1);
    n = 0;
    while ((acceptedCount - startAcc) < 3 && n < 20) begin
      tick(1);
      n++;
    end
    checkOutput("t6ThreeBytes", 32'(acceptedCount - startAcc), 32'd3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    expBytes.delete();
    checkResetState();
    startAcc = acceptedCount;
    pushRecord(8'h4A, 32'h0000_0400, 32'h0BAD_F00D);
    applyStimulus(1'b1, 32'h0000_0400, 32'h0BAD_F00D, 5'd10, 1'b1);
    waitDrain("t6Drain", 40, 1'b0);
    checkOutput("t6FullPacket", 32'(acceptedCount - startAcc), 32'd9);

    // T4: exit rises together with a retirement; later activity is ignored
    resetDut();
    startValid = validCycles;
    pushRecord(8'hC2, 32'h0000_0200, 32'h1234_5678);
    retExit = 1'b1;
    applyStimulus(1'b1, 32'h0000_0200, 32'h1234_5678, 5'd2, 1'b1);
    checkOutput("t4DoneEarly", 32'(done), 32'd0);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 32'h0000_0204 + 32'(4 * i), 32'h0000_0013, 5'd4, 1'b1);
    end
    retExit = 1'b0;
    tick(1);
    retExit = 1'b1;
    applyStimulus(1'b1, 32'h0000_0300, 32'h0000_0013, 5'd6, 1'b1);
    waitDrain("t4Drain", 60, 1'b0);
    checkOutput("t4Done", 32'(done), 32'd1);
    checkOutput("t4OnePacket", 32'(validCycles - startValid), 32'd9);
    checkOutput("t4FifoEmpty", 32'(fifoCount), 32'd0);
    tick(3);
    checkOutput("t4ParkedIdle", 32'(txValid), 32'd0);

    // T5: exit arrives while the FIFO is full and must not be dropped
    resetDut();
    txReady = 1'b0;
    for (int i = 0; i < 17; i++) begin
      pushRecord(8'h40 | 8'(i), 32'(4 * i), 32'h2000_0000 + 32'(i));
      applyStimulus(1'b1, 32'(4 * i), 32'h2000_0000 + 32'(i), 5'(i), 1'b1);
    end
    pushRecord(8'h80, 32'h0000_0000, 32'h0000_0000);
    retExit = 1'b1;
    applyStimulus(1'b0, 32'h0000_0000, 32'h0000_0000, 5'd0, 1'b0);
    checkOutput("t5FifoFull", 32'(fifoCount), 32'd16);
    checkOutput("t5NoDrop", 32'(dropCount), 32'd0);
    checkOutput("t5NoOverflow", 32'(overflow), 32'd0);
    checkOutput("t5NotDone", 32'(done), 32'd0);
    txReady = 1'b1;
    waitDrain("t5Drain", 400, 1'b0);
    checkOutput("t5Done", 32'(done), 32'd1);
    checkOutput("t5DropsStillZero", 32'(dropCount), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
